// File: rtl/booth_mul_sat.sv
// Sequential radix-2 Booth signed fixed-point multiplier with truncation and saturation to the output format.
// Optional BOOTHMUL_OVF_EN adds a registered ovf port that flags a clamped result.
module booth_mul_sat #(
    parameter int A1_WHOLE  = 8,
    parameter int A1_FRAC   = 8,
    parameter int A2_WHOLE  = 8,
    parameter int A2_FRAC   = 8,
    parameter int OUT_WHOLE = 12,
    parameter int OUT_FRAC  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              arm,
    input  logic [A1_WHOLE+A1_FRAC-1:0]       a1,
    input  logic [A2_WHOLE+A2_FRAC-1:0]       a2,
    output logic [OUT_WHOLE+OUT_FRAC-1:0]     outp,
    output logic                              fin
`ifdef BOOTHMUL_OVF_EN
    ,
    output logic                              ovf
`endif
);

    localparam int A1_LEN  = A1_WHOLE + A1_FRAC;
    localparam int A2_LEN  = A2_WHOLE + A2_FRAC;
    localparam int OUT_LEN = OUT_WHOLE + OUT_FRAC;
    localparam int PW      = A1_LEN + A2_LEN;
    localparam int SH      = A1_FRAC + A2_FRAC - OUT_FRAC;
    localparam int TW      = PW - SH;
    localparam int CW      = $clog2(A2_LEN + 1);

    if (OUT_FRAC > A1_FRAC + A2_FRAC) begin : g_badFrac
        $error("booth_mul_sat: OUT_FRAC must not exceed A1_FRAC+A2_FRAC");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                r_state;
    logic signed [A1_LEN:0] r_acc;
    logic signed [A1_LEN:0] r_mcand;
    logic [A2_LEN-1:0]     r_q;
    logic                  r_qPrev;
    logic [CW-1:0]         r_cnt;

    logic signed [A1_LEN:0] w_sum;
    logic [A1_LEN:0]       w_accNext;
    logic [A2_LEN-1:0]     w_qNext;
    logic [PW-1:0]         w_prod;
    logic [TW-1:0]         w_trunc;
    logic [OUT_LEN-1:0]    w_sat;
    logic                  w_clamp;

    // Accumulator is one bit wider than a1 so that subtracting the most negative a1 cannot wrap.
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_qPrev})
            2'b10:   w_sum = r_acc - r_mcand;
            2'b01:   w_sum = r_acc + r_mcand;
            default: w_sum = r_acc;
        endcase
    end

    assign w_accNext = {w_sum[A1_LEN], w_sum[A1_LEN:1]};
    assign w_qNext   = {w_sum[0], r_q[A2_LEN-1:1]};
    assign w_prod    = {w_accNext[A1_LEN-1:0], w_qNext};
    assign w_trunc   = w_prod[PW-1:SH];

    if (SH > 0) begin : g_dropLow
        logic w_unusedLow;
        assign w_unusedLow = ^w_prod[SH-1:0];
    end

    if (OUT_LEN > TW) begin : g_extend
        assign w_sat   = {{(OUT_LEN-TW){w_trunc[TW-1]}}, w_trunc};
        assign w_clamp = 1'b0;
    end else if (OUT_LEN == TW) begin : g_pass
        assign w_sat   = w_trunc;
        assign w_clamp = 1'b0;
    end else begin : g_saturate
        logic [TW-OUT_LEN:0] w_hi;
        assign w_hi    = w_trunc[TW-1:OUT_LEN-1];
        assign w_clamp = ~((&w_hi) | ~(|w_hi));
        assign w_sat   = !w_clamp ? w_trunc[OUT_LEN-1:0] :
                         (w_trunc[TW-1] ? {1'b1, {(OUT_LEN-1){1'b0}}}
                                        : {1'b0, {(OUT_LEN-1){1'b1}}});
    end

    // The last Booth step registers the finished, scaled product directly so fin needs no extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_q     <= '0;
            r_qPrev <= 1'b0;
            r_cnt   <= '0;
            outp    <= '0;
            fin     <= 1'b0;
`ifdef BOOTHMUL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) r_state <= LOAD;
                end
                LOAD: begin
                    if (!arm) begin
                        r_state <= IDLE;
                    end else begin
                        r_mcand <= {a1[A1_LEN-1], a1};
                        r_q     <= a2;
                        r_qPrev <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
`ifdef BOOTHMUL_OVF_EN
                        ovf     <= 1'b0;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!arm) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc   <= w_accNext;
                        r_q     <= w_qNext;
                        r_qPrev <= r_q[0];
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CW'(A2_LEN - 1)) begin
                            outp    <= w_sat;
                            fin     <= 1'b1;
`ifdef BOOTHMUL_OVF_EN
                            ovf     <= w_clamp;
`endif
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!arm) begin
                        fin     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_sat.sv
// Self-checking bench for booth_mul_sat: default Q12.8 instance plus a wide (OUT_WHOLE=17) instance.
// Expected results come from plain integer multiply, floor shift and clamp; build with BOOTHMUL_OVF_EN to check ovf.
module tb_booth_mul_sat;

    localparam int A2_LEN   = 16;
    localparam int OUT_LEN  = 20;
    localparam int WIDE_LEN = 25;
    localparam int LAT      = A2_LEN + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [19:0] outp;
    logic        fin;
    logic [24:0] outpWide;
    logic        finWide;
`ifdef BOOTHMUL_OVF_EN
    logic        ovf;
    logic        ovfWide;
    logic        expOvf;
`endif

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [19:0] expOutp;
    logic [24:0] expWide;
    logic        expFin;
    bit          checkEn = 1'b0;

    always #5 clk = ~clk;

    booth_mul_sat #(
        .A1_WHOLE(8), .A1_FRAC(8), .A2_WHOLE(8), .A2_FRAC(8), .OUT_WHOLE(12), .OUT_FRAC(8)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .arm  (arm),
        .a1   (a1),
        .a2   (a2),
        .outp (outp),
        .fin  (fin)
`ifdef BOOTHMUL_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    booth_mul_sat #(
        .A1_WHOLE(8), .A1_FRAC(8), .A2_WHOLE(8), .A2_FRAC(8), .OUT_WHOLE(17), .OUT_FRAC(8)
    ) u_dutWide (
        .clk  (clk),
        .rst  (rst),
        .arm  (arm),
        .a1   (a1),
        .a2   (a2),
        .outp (outpWide),
        .fin  (finWide)
`ifdef BOOTHMUL_OVF_EN
        ,
        .ovf  (ovfWide)
`endif
    );

    // Reference: exact product, floor-shift away the surplus fraction bits, clamp to the output range.
    function automatic longint modelOut(input logic [15:0] x, input logic [15:0] y,
                                        input int outLen, output bit clamped);
        longint p;
        longint t;
        longint mx;
        longint mn;
        p  = longint'($signed(x)) * longint'($signed(y));
        t  = p >>> 8;
        mx = (longint'(1) <<< (outLen - 1)) - 1;
        mn = -(longint'(1) <<< (outLen - 1));
        clamped = 1'b0;
        if (t > mx) begin
            t = mx;
            clamped = 1'b1;
        end else if (t < mn) begin
            t = mn;
            clamped = 1'b1;
        end
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle both instances must match the model's view of fin and outp.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("fin", {63'd0, fin}, {63'd0, expFin});
            checkOutput("outp", {44'd0, outp}, {44'd0, expOutp});
            checkOutput("finWide", {63'd0, finWide}, {63'd0, expFin});
            checkOutput("outpWide", {39'd0, outpWide}, {39'd0, expWide});
`ifdef BOOTHMUL_OVF_EN
            checkOutput("ovf", {63'd0, ovf}, {63'd0, expOvf});
            checkOutput("ovfWide", {63'd0, ovfWide}, 64'd0);
`endif
        end
    end

    // One full operation: arm, scramble operands after LOAD, hold DONE, then drop arm for one edge.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input int holdCycles);
        bit     c;
        bit     unusedClamp;
        longint r;
        longint rw;
        r  = modelOut(x, y, OUT_LEN, c);
        rw = modelOut(x, y, WIDE_LEN, unusedClamp);
        a1  = x;
        a2  = y;
        arm = 1'b1;
        tick();
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) begin
`ifdef BOOTHMUL_OVF_EN
                expOvf = 1'b0;
`endif
                a1 = 16'($urandom);
                a2 = 16'($urandom);
            end
            if (k == LAT) begin
                expFin  = 1'b1;
                expOutp = r[19:0];
                expWide = rw[24:0];
`ifdef BOOTHMUL_OVF_EN
                expOvf  = c;
`endif
            end
        end
        repeat (holdCycles) tick();
        arm = 1'b0;
        tick();
        expFin = 1'b0;
    endtask

    task automatic applyAbort(input logic [15:0] x, input logic [15:0] y, input int dropAt);
        a1  = x;
        a2  = y;
        arm = 1'b1;
        tick();
        repeat (dropAt) tick();
        arm = 1'b0;
        repeat (LAT + 3) tick();
        checkOutput("abortNoFin", {63'd0, fin}, 64'd0);
    endtask

    task automatic applyResetMidRun(input logic [15:0] x, input logic [15:0] y, input int rstAt);
        a1  = x;
        a2  = y;
        arm = 1'b1;
        tick();
        repeat (rstAt) tick();
        rst = 1'b1;
        tick();
        expFin  = 1'b0;
        expOutp = '0;
        expWide = '0;
`ifdef BOOTHMUL_OVF_EN
        expOvf  = 1'b0;
`endif
        rst = 1'b0;
        arm = 1'b0;
        tick();
        checkOutput("rstMidRunOutp", {44'd0, outp}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        a1  = '0;
        a2  = '0;
        repeat (3) tick();
        expFin  = 1'b0;
        expOutp = '0;
        expWide = '0;
`ifdef BOOTHMUL_OVF_EN
        expOvf  = 1'b0;
`endif
        checkEn = 1'b1;
        rst = 1'b0;
        checkOutput("resetFin", {63'd0, fin}, 64'd0);
        checkOutput("resetOutp", {44'd0, outp}, 64'd0);

        applyStimulus(16'h0180, 16'h0200, 2);
        checkOutput("lit1p5x2", {44'd0, outp}, 64'h00300);
        applyStimulus(16'hFF00, 16'h0080, 0);
        checkOutput("litNeg1xHalf", {44'd0, outp}, 64'hFFF80);
        applyStimulus(16'h7F00, 16'h7F00, 1);
        checkOutput("litSatPos", {44'd0, outp}, 64'h7FFFF);
`ifdef BOOTHMUL_OVF_EN
        checkOutput("litSatPosOvf", {63'd0, ovf}, 64'd1);
`endif
        applyStimulus(16'h8000, 16'h7F00, 0);
        checkOutput("litSatNeg", {44'd0, outp}, 64'h80000);
        applyStimulus(16'h0001, 16'h0001, 0);
        checkOutput("litTinyPos", {44'd0, outp}, 64'h00000);
        applyStimulus(16'hFFFF, 16'h0001, 0);
        checkOutput("litFloorNeg", {44'd0, outp}, 64'hFFFFF);
        applyStimulus(16'h8000, 16'h8000, 0);
        checkOutput("litMinMinWide", {39'd0, outpWide}, 64'h0400000);
        checkOutput("litMinMinSat", {44'd0, outp}, 64'h7FFFF);

        applyResetMidRun(16'h1234, 16'h0567, 6);
        applyAbort(16'h0300, 16'h0400, 5);
        checkOutput("abortOutpHeld", {44'd0, outp}, 64'd0);
        applyStimulus(16'h0180, 16'h0200, 0);
        applyAbort(16'h7000, 16'h7000, 9);
        checkOutput("abortOutpKept", {44'd0, outp}, 64'h00300);

        for (int i = 0; i < 30; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 5 == 0) x = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            if (i % 7 == 0) y = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'hFFFF;
            applyStimulus(x, y, $urandom_range(0, 3));
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        testsFailed++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
